// File: rtl/oled_frame_arbiter.sv
// Round-robin arbiter that grants one of two OLED text sources, latches its frame
// and streams it MSB-byte first over the sendData/sendDataValid/sendDone handshake.
//
// state    | meaning
// IDLE     | waiting for a request; grants on the edge a request is seen
// START    | frame latched; updateString raised for the next cycle
// WAIT_LOW | waiting for sendDone low before presenting the next byte
// SEND     | byte valid; waiting for sendDone high
// HOLD     | refresh hold-off after the last byte, requests ignored
module oled_frame_arbiter #(
   parameter int STRING_LEN     = 64,
   parameter int REFRESH_CYCLES = 500000
) (
   input  logic                    CLK100MHZ,
   input  logic                    reset,
   input  logic                    req0,
   input  logic [8*STRING_LEN-1:0] msg0,
   output logic                    ack0,
   input  logic                    req1,
   input  logic [8*STRING_LEN-1:0] msg1,
   output logic                    ack1,
   output logic [7:0]              sendData,
   output logic                    sendDataValid,
   input  logic                    sendDone,
   output logic                    updateString,
   output logic                    busy,
   output logic                    active_src
);

   localparam int FW     = 8*STRING_LEN;
   localparam int CNT_W  = $clog2(STRING_LEN+1);
   localparam int HOLD_W = $clog2(REFRESH_CYCLES+1);
   localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(STRING_LEN);
   localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(REFRESH_CYCLES-1);

   typedef enum logic [2:0] {IDLE, START, WAIT_LOW, SEND, HOLD} state_t;

   state_t            state_q, state_d;
   logic [FW-1:0]     frame_q, frame_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic              ack0_q, ack0_d, ack1_q, ack1_d;
   logic [7:0]        data_q, data_d;
   logic              valid_q, valid_d;
   logic              upd_q, upd_d;
   logic              busy_q, busy_d;
   logic              src_q, src_d;
   logic              grant1;

   always_comb begin
      state_d = state_q;
      frame_d = frame_q;
      cnt_d   = cnt_q;
      hold_d  = hold_q;
      ack0_d  = 1'b0;
      ack1_d  = 1'b0;
      data_d  = data_q;
      valid_d = valid_q;
      upd_d   = 1'b0;
      src_d   = src_q;
      grant1  = 1'b0;
      case (state_q)
         IDLE: begin
            if (req0 || req1) begin
               // on a tie the source that did not win last time goes next
               grant1  = (req0 && req1) ? ~src_q : req1;
               frame_d = grant1 ? msg1 : msg0;
               ack0_d  = ~grant1;
               ack1_d  = grant1;
               src_d   = grant1;
               cnt_d   = CNT_FULL;
               state_d = START;
            end
         end
         START: begin
            upd_d   = 1'b1;
            state_d = WAIT_LOW;
         end
         WAIT_LOW: begin
            if (!sendDone) begin
               data_d  = frame_q[FW-1 -: 8];
               valid_d = 1'b1;
               state_d = SEND;
            end
         end
         SEND: begin
            if (sendDone) begin
               valid_d = 1'b0;
               cnt_d   = cnt_q - 1'b1;
               // shifting keeps the next byte at the top, so the byte mux is a fixed slice
               frame_d = frame_q << 8;
               if (cnt_q == CNT_W'(1)) begin
                  hold_d  = HOLD_LOAD;
                  state_d = HOLD;
               end else begin
                  state_d = WAIT_LOW;
               end
            end
         end
         HOLD: begin
            if (hold_q == '0) state_d = IDLE;
            else              hold_d  = hold_q - 1'b1;
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge CLK100MHZ or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         frame_q <= '0;
         cnt_q   <= CNT_FULL;
         hold_q  <= '0;
         ack0_q  <= 1'b0;
         ack1_q  <= 1'b0;
         data_q  <= 8'h00;
         valid_q <= 1'b0;
         upd_q   <= 1'b0;
         busy_q  <= 1'b0;
         src_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         frame_q <= frame_d;
         cnt_q   <= cnt_d;
         hold_q  <= hold_d;
         ack0_q  <= ack0_d;
         ack1_q  <= ack1_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         upd_q   <= upd_d;
         busy_q  <= busy_d;
         src_q   <= src_d;
      end
   end

   assign ack0          = ack0_q;
   assign ack1          = ack1_q;
   assign sendData      = data_q;
   assign sendDataValid = valid_q;
   assign updateString  = upd_q;
   assign busy          = busy_q;
   assign active_src    = src_q;

endmodule

// File: tb/tb_oled_frame_arbiter.sv
// Directed bench for oled_frame_arbiter with a small oledControl done-handshake model.
module tb_oled_frame_arbiter;

   localparam int SL = 4;
   localparam int RC = 10;

   localparam int W_ACK0     = 0;
   localparam int W_ACK1     = 1;
   localparam int W_VALID_HI = 2;
   localparam int W_VALID_LO = 3;
   localparam int W_BUSY_LO  = 4;
   localparam int W_ACK_ANY  = 5;
   localparam int W_DONE_LO  = 6;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          req0 = 1'b0, req1 = 1'b0;
   logic [8*SL-1:0] msg0 = '0, msg1 = '0;
   logic          ack0, ack1;
   logic [7:0]    sendData;
   logic          sendDataValid;
   logic          sendDone = 1'b0;
   logic          updateString, busy, active_src;

   int cyc = 0;
   int force_until = 0;
   int hi_cnt = 0, lo_cnt = 0;
   int checks = 0, failures = 0;

   oled_frame_arbiter #(.STRING_LEN(SL), .REFRESH_CYCLES(RC)) dut (
      .CLK100MHZ(clk), .reset(reset),
      .req0(req0), .msg0(msg0), .ack0(ack0),
      .req1(req1), .msg1(msg1), .ack1(ack1),
      .sendData(sendData), .sendDataValid(sendDataValid), .sendDone(sendDone),
      .updateString(updateString), .busy(busy), .active_src(active_src)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // oledControl model: done rises 3 edges after valid, falls 2 edges after valid drops
   always @(posedge clk) begin
      if (cyc < force_until) begin
         sendDone <= 1'b1;
         hi_cnt   <= 0;
         lo_cnt   <= 0;
      end else if (sendDataValid) begin
         lo_cnt <= 0;
         if (hi_cnt >= 2) sendDone <= 1'b1;
         else             hi_cnt   <= hi_cnt + 1;
      end else begin
         hi_cnt <= 0;
         if (sendDone) begin
            if (lo_cnt >= 1) begin
               sendDone <= 1'b0;
               lo_cnt   <= 0;
            end else begin
               lo_cnt <= lo_cnt + 1;
            end
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_cond(input int which, input int budget, input string tag, output int at);
      bit hit;
      hit = 1'b0;
      at  = -1;
      for (int i = 0; i < budget && !hit; i++) begin
         @(negedge clk);
         case (which)
            W_ACK0:     hit = ack0;
            W_ACK1:     hit = ack1;
            W_VALID_HI: hit = sendDataValid;
            W_VALID_LO: hit = !sendDataValid;
            W_BUSY_LO:  hit = !busy;
            W_ACK_ANY:  hit = ack0 | ack1;
            W_DONE_LO:  hit = !sendDone;
            default:    hit = 1'b0;
         endcase
         if (hit) at = cyc;
      end
      if (!hit) begin
         checks++;
         failures++;
         $error("FAIL %s timeout observed=none expected=event", tag);
      end
   endtask

   task automatic recv_frame(input logic [31:0] exp, input bit first_present,
                             input string tag, output int last_fall);
      int t;
      logic [7:0] eb;
      last_fall = -1;
      for (int i = 0; i < SL; i++) begin
         eb = exp[31-8*i -: 8];
         if (!(i == 0 && first_present)) wait_cond(W_VALID_HI, 20, {tag, "_vhi"}, t);
         check({tag, "_byte"}, {24'h0, sendData}, {24'h0, eb});
         wait_cond(W_VALID_LO, 20, {tag, "_vlo"}, t);
         check({tag, "_hold"}, {24'h0, sendData}, {24'h0, eb});
         last_fall = t;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      int r, a, e, b, d, v;
      int exp_src;

      // reset values
      repeat (2) @(negedge clk);
      check("rst_ack0",  {31'h0, ack0}, 32'h0);
      check("rst_ack1",  {31'h0, ack1}, 32'h0);
      check("rst_valid", {31'h0, sendDataValid}, 32'h0);
      check("rst_upd",   {31'h0, updateString}, 32'h0);
      check("rst_busy",  {31'h0, busy}, 32'h0);
      check("rst_data",  {24'h0, sendData}, 32'h0);
      check("rst_src",   {31'h0, active_src}, 32'h1);
      reset = 1'b0;

      // single source, frame immune to msg0 changes after the grant
      @(negedge clk);
      msg0 = "ABCD";
      req0 = 1'b1;
      r = cyc;
      wait_cond(W_ACK0, 10, "t1_ack0", a);
      check("t1_ack_lat", a, r + 1);
      check("t1_src", {31'h0, active_src}, 32'h0);
      check("t1_busy", {31'h0, busy}, 32'h1);
      req0 = 1'b0;
      msg0 = "zzzz";
      @(negedge clk);
      check("t1_ack0_pulse", {31'h0, ack0}, 32'h0);
      check("t1_upd", {31'h0, updateString}, 32'h1);
      recv_frame("ABCD", 1'b0, "t1", e);
      wait_cond(W_BUSY_LO, 20, "t1_busy_lo", b);
      check("t1_busy_fall", b, e + RC);
      check("t1_src_end", {31'h0, active_src}, 32'h0);

      // simultaneous first requests after reset
      do_reset();
      msg0 = "ABCD";
      msg1 = "WXYZ";
      req0 = 1'b1;
      req1 = 1'b1;
      wait_cond(W_ACK0, 10, "t2_ack0", a);
      check("t2_no_ack1", {31'h0, ack1}, 32'h0);
      req0 = 1'b0;
      recv_frame("ABCD", 1'b0, "t2a", e);
      wait_cond(W_ACK1, 20, "t2_ack1", a);
      check("t2_ack1_time", a, e + RC + 1);
      check("t2_src", {31'h0, active_src}, 32'h1);
      req1 = 1'b0;
      recv_frame("WXYZ", 1'b0, "t2b", e);
      wait_cond(W_BUSY_LO, 20, "t2_busy_lo", b);

      // round robin with both requests held
      req0 = 1'b1;
      req1 = 1'b1;
      for (int f = 0; f < 4; f++) begin
         exp_src = f % 2;
         wait_cond(W_ACK_ANY, 20, "t3_ack", a);
         check("t3_order", {31'h0, ack1}, exp_src);
         check("t3_excl", {31'h0, ack0 & ack1}, 32'h0);
         if (f == 3) begin
            req0 = 1'b0;
            req1 = 1'b0;
         end
         recv_frame(exp_src == 1 ? 32'h5758595A : 32'h41424344, 1'b0, "t3", e);
      end
      wait_cond(W_BUSY_LO, 20, "t3_busy_lo", b);

      // request arriving during hold-off
      req0 = 1'b1;
      wait_cond(W_ACK0, 10, "t4_ack0", a);
      req0 = 1'b0;
      recv_frame("ABCD", 1'b0, "t4a", e);
      repeat (3) @(negedge clk);
      req1 = 1'b1;
      wait_cond(W_ACK1, 20, "t4_ack1", a);
      check("t4_ack1_time", a, e + RC + 1);
      req1 = 1'b0;
      recv_frame("WXYZ", 1'b0, "t4b", e);
      wait_cond(W_BUSY_LO, 20, "t4_busy_lo", b);

      // reset while byte 2 is valid
      req0 = 1'b1;
      wait_cond(W_ACK0, 10, "t5_ack0", a);
      req0 = 1'b0;
      wait_cond(W_VALID_HI, 20, "t5_b1hi", v);
      wait_cond(W_VALID_LO, 20, "t5_b1lo", v);
      wait_cond(W_VALID_HI, 20, "t5_b2hi", v);
      check("t5_byte2", {24'h0, sendData}, 32'h42);
      reset = 1'b1;
      #1;
      check("t5_valid", {31'h0, sendDataValid}, 32'h0);
      check("t5_busy",  {31'h0, busy}, 32'h0);
      check("t5_data",  {24'h0, sendData}, 32'h0);
      check("t5_src",   {31'h0, active_src}, 32'h1);
      check("t5_upd",   {31'h0, updateString}, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      req0 = 1'b1;
      r = cyc;
      wait_cond(W_ACK0, 10, "t5_ack0b", a);
      check("t5_ack_lat", a, r + 1);
      req0 = 1'b0;
      recv_frame("ABCD", 1'b0, "t5", e);
      wait_cond(W_BUSY_LO, 20, "t5_busy_lo", b);

      // sendDone already high when the frame starts
      msg0 = "QRST";
      req0 = 1'b1;
      wait_cond(W_ACK0, 10, "t6_ack0", a);
      req0 = 1'b0;
      force_until = cyc + 6;
      @(negedge clk);
      check("t6_upd", {31'h0, updateString}, 32'h1);
      @(negedge clk);
      check("t6_done_hi", {31'h0, sendDone}, 32'h1);
      check("t6_valid_lo", {31'h0, sendDataValid}, 32'h0);
      wait_cond(W_DONE_LO, 20, "t6_done_lo", d);
      check("t6_valid_still_lo", {31'h0, sendDataValid}, 32'h0);
      wait_cond(W_VALID_HI, 20, "t6_vhi", v);
      check("t6_valid_time", v, d + 1);
      recv_frame("QRST", 1'b1, "t6", e);
      wait_cond(W_BUSY_LO, 20, "t6_busy_lo", b);
      check("t6_busy_fall", b, e + RC);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/oled_frame_arbiter.md
# oled_frame_arbiter

Shares the OLED character-stream interface (`oledControl`'s `sendData`/`sendDataValid`/`sendDone`/`updateString`) between two message sources, for example the joystick direction text and a status/alert text. Each source presents a full frame of `STRING_LEN` ASCII bytes and a request. The block grants one source at a time using round-robin, latches its frame, and streams the bytes most significant first through the byte handshake. It then enforces a refresh hold-off before the next frame. It sits between the message-generation logic and `oledControl` in the top level and replaces the inline byte-streaming FSM.

## Interface
Parameters:
- `STRING_LEN`, 64: characters per frame. Frame width is 8*STRING_LEN bits.
- `REFRESH_CYCLES`, 500000: hold-off in clocks after a frame completes. Must be ≥ 1.

Ports:
- `CLK100MHZ`  in  1  sole clock; all logic rises on its positive edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req0`  in  1  source 0 request, level. Held until `ack0`.
- `msg0`  in  8*STRING_LEN  source 0 frame. Byte STRING_LEN-1 (bits [8*STRING_LEN-1 -: 8]) is shown first.
- `ack0`  out  1  one-cycle pulse: `msg0` has been latched.
- `req1`, `msg1`, `ack1`: same as source 0, for source 1.
- `sendData`  out  8  byte to `oledControl`.
- `sendDataValid`  out  1  byte valid.
- `sendDone`  in  1  `oledControl` byte accepted, level.
- `updateString`  out  1  one-cycle pulse marking the start of a frame.
- `busy`  out  1  high in every state except IDLE.
- `active_src`  out  1  index of the source that was granted last.

## Operation
- All outputs are registered.
- Reset values: `ack0`=`ack1`=`sendDataValid`=`updateString`=`busy`=0, `sendData`=8'h00, `active_src`=1. State is IDLE, the hold-off counter is 0 and the byte counter is STRING_LEN.
- Because `active_src` resets to 1, source 0 wins the first tie.
- States and transitions:
  - IDLE: If one request is high, grant it. If both are high, grant the source ≠ `active_src`. On a grant: latch `msgX` into the frame register, pulse `ackX`, set `active_src`=X, set byte counter = STRING_LEN, go to START. With no request, stay in IDLE.
  - START: `updateString`=1 for exactly this cycle, then go to WAIT_LOW.
  - WAIT_LOW: Wait for `sendDone`==0. Then `sendData` ← frame[(cnt*8-1) -: 8] and `sendDataValid` ← 1, go to SEND.
  - SEND: Wait for `sendDone`==1. Then `sendDataValid` ← 0 and cnt ← cnt-1. If the old cnt was 1, load hold-off = REFRESH_CYCLES-1 and go to HOLD; otherwise go to WAIT_LOW.
  - HOLD: Decrement the hold-off counter. At 0, go to IDLE. Requests are ignored in HOLD.
- `sendData` holds its value until the next load. `sendDataValid` stays high until `sendDone` is seen.
- The frame register is immune to changes on `msgX` after the grant.
- A request dropped before its grant is simply never served; no state is kept.
- `reqX` may stay high after `ackX`. It is then treated as a new request at the next IDLE.
- Reset mid-frame aborts immediately with no partial-frame recovery. The next grant starts from byte STRING_LEN-1.

## Timing
- Request to grant: a request sampled high in IDLE at edge k produces `ackX`=1 during cycle k..k+1.
- `updateString`=1 during the following cycle.
- The earliest `sendDataValid` rises 2 edges after `ack`, provided `sendDone` is low.
- Per byte: at least 2 clocks (WAIT_LOW→SEND→WAIT_LOW), plus `oledControl` latency.
- Frame to next grant: exactly REFRESH_CYCLES clocks in HOLD, then 1 IDLE cycle.
- If `sendDone` is stuck high at WAIT_LOW, the block waits indefinitely with valid low.

## Test plan
Simulate with STRING_LEN=4 and REFRESH_CYCLES=10, using an `oledControl` model that raises `sendDone` 3 cycles after valid and lowers it 2 cycles after valid falls.
- **Single source:** `req0`=1, `msg0`="ABCD". Expect `ack0` to pulse once, then `updateString` one cycle later, then bytes 8'h41,42,43,44 in order, each with valid held until done. `busy` falls 11 cycles after the last done, and `active_src`=0.
- **Simultaneous first requests:** `req0`=`req1`=1 after reset. Source 0 ("ABCD") is sent first. `ack1` fires exactly 11 cycles after the frame-0 HOLD entry, then "WXYZ" is streamed.
- **Round-robin:** both requests held high for 4 frames. Expect sources in the order 0,1,0,1, with no two consecutive grants to the same source.
- **Hold-off:** `req1` rises 3 cycles into HOLD. No `ack1` is issued until HOLD expires, then `ack1` follows on the next edge.
- **Reset mid-frame:** assert `reset` while byte 2 is valid. All outputs go to their reset values asynchronously. A new `req0` restarts the stream at 8'h41.
- **`sendDone` high at grant:** the model holds done high for 5 cycles after `updateString`. `sendDataValid` must stay 0 until done falls, then the first byte is presented.
